var_delay_pipe: RTL and testbench
=================================

VAR_DELAY_PIPE -- requirements
Module: var_delay_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width in bits (>=1).
REQ-002 SHALL have parameter MAX_DEPTH, default 16, meaning number of physical stages and maximum delay (>=1).
REQ-003 SHALL have derived localparam DW = $clog2(MAX_DEPTH+1), meaning width of delay and count fields.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-006 SHALL have port din, input, WIDTH, meaning input data.
REQ-007 SHALL have port valid_in, input, 1, meaning din qualifier.
REQ-008 SHALL have port en, input, 1, meaning pipeline advance; 0 freezes all stages and outputs.
REQ-009 SHALL have port flush, input, 1, meaning synchronous clear of all in-flight samples.
REQ-010 SHALL have port delay, input, DW, meaning requested delay in enabled cycles.
REQ-011 SHALL have port dout, output, WIDTH, meaning delayed data (registered).
REQ-012 SHALL have port valid_out, output, 1, meaning dout qualifier (registered).
REQ-013 SHALL have port inflight, output, DW, meaning accepted samples not yet presented on valid_out.
REQ-014 SHALL have port cfg_err, output, 1, meaning sticky flag for an out-of-range delay request.

Function
REQ-015 Sample SHALL be accepted only on an edge with valid_in=1, en=1, flush=0; valid_in with en=0 is ignored and not stored.
REQ-016 Stages SHALL be MAX_DEPTH entries of {valid,data}; on an enabled edge, stage0 <= {accept,din} and stage[i] <= stage[i-1].
REQ-017 Effective delay ED SHALL be: if inflight==0, clamp(delay) to 1..MAX_DEPTH; otherwise the registered current delay CD.
REQ-018 CD SHALL load ED every edge, so delay changes take effect only while empty; a sample accepted on the edge that CD loads uses the new ED.
REQ-019 On an enabled edge, {valid_out,dout} SHALL load stage[ED-1] as it was before the edge; latency is exactly ED enabled edges from acceptance to valid_out=1.
REQ-020 Stage valid bits at index >= ED SHALL be forced to 0 on every enabled edge, so no stale sample ever surfaces after a delay increase.
REQ-021 With en=0, stages, dout, valid_out, inflight and CD SHALL hold; cfg_err still updates.
REQ-022 inflight SHALL be +1 on acceptance and -1 when a valid stage[ED-1] moves to the output; both on one edge leaves it unchanged; max value is ED.
REQ-023 flush=1 SHALL have priority over en: next edge clears all stage valid bits, valid_out, inflight and cfg_err; valid_in that cycle is discarded; data bits are don't-care.
REQ-024 cfg_err SHALL set on the edge after delay==0 or delay>MAX_DEPTH is sampled while inflight==0 (regardless of en) and hold until flush or reset.
REQ-025 dout SHALL be don't-care when valid_out=0; checkers compare dout only when valid_out=1.
REQ-026 Order SHALL be preserved; no sample is ever duplicated or dropped except by flush or reset.

Reset
REQ-027 rst=1 SHALL asynchronously clear all stage valid bits, valid_out=0, dout=0, inflight=0, cfg_err=0, CD=1.
REQ-028 First edge after rst deasserts SHALL behave as normal operation (ED from delay input, since inflight==0).
REQ-029 rst asserted mid-stream SHALL lose all in-flight samples; none appear after release.

Verification
REQ-030 delay=4, en=1, valid_in pulsed with din=0xA5 at edge 10 -> valid_out=1, dout=0xA5 after edge 14 only; inflight 1 during edges 10..13.
REQ-031 delay=3, back-to-back din 1..8, en low for 2 cycles mid-stream -> outputs 1..8 in order, each latency 3 enabled edges, output frozen during stall.
REQ-032 delay=5 with 3 in flight, delay changed to 2 -> those 3 emerge at delay 5; first sample accepted after inflight hits 0 emerges after 2 edges; no phantom valid_out after later change to 8.
REQ-033 delay=6, 4 samples in flight, flush=1 with valid_in=1 -> next edge inflight=0, valid_out=0, no further outputs.
REQ-034 delay=0 then delay=MAX_DEPTH+1 while empty -> cfg_err=1 after first; effective delays 1 and MAX_DEPTH; cfg_err clears only on flush.
REQ-035 rst pulsed asynchronously between edges with 3 in flight -> outputs zero immediately; no valid_out after release with valid_in=0.

Source files
------------

// File: rtl/var_delay_pipe.sv
// -----------------------------------------------------------------------------
// var_delay_pipe
// Pipeline with a run-time selectable delay of 1..MAX_DEPTH enabled cycles.
// A requested delay is latched only while the pipe is empty, so samples that
// are already in flight always leave with the delay they entered with.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   din       : input data
//   valid_in  : din qualifier
//   en        : advance the pipe; 0 freezes stages and outputs
//   flush     : synchronous clear of every in-flight sample (wins over en)
//   delay     : requested delay in enabled cycles
//   dout      : delayed data (registered, meaningful only with valid_out)
//   valid_out : dout qualifier (registered)
//   inflight  : accepted samples not yet presented on valid_out
//   cfg_err   : sticky flag, set by an out-of-range delay seen while empty
// -----------------------------------------------------------------------------
module var_delay_pipe #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               din,
  input  logic                           valid_in,
  input  logic                           en,
  input  logic                           flush,
  input  logic [$clog2(MAX_DEPTH+1)-1:0] delay,
  output logic [WIDTH-1:0]               dout,
  output logic                           valid_out,
  output logic [$clog2(MAX_DEPTH+1)-1:0] inflight,
  output logic                           cfg_err
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] ZERO_D = {DW{1'b0}};
  localparam logic [DW-1:0] ONE_D  = DW'(32'd1);
  localparam logic [DW-1:0] MAX_D  = DW'(MAX_DEPTH);

  // Registered state
  logic [MAX_DEPTH-1:0]            stage_vld_r;
  logic [MAX_DEPTH-1:0][WIDTH-1:0] stage_dat_r;
  logic [DW-1:0]                   cd_r;
  logic [DW-1:0]                   inflight_r;
  logic [WIDTH-1:0]                dout_r;
  logic                            valid_out_r;
  logic                            cfg_err_r;

  // Combinational next-state
  logic [DW-1:0]                   ed_s;
  logic                            delay_bad_s;
  logic                            accept_s;
  logic                            tap_vld_s;
  logic [WIDTH-1:0]                tap_dat_s;
  logic [MAX_DEPTH-1:0]            nxt_vld_s;
  logic [MAX_DEPTH-1:0][WIDTH-1:0] nxt_dat_s;
  logic [DW-1:0]                   inflight_nxt_s;

  assign dout      = dout_r;
  assign valid_out = valid_out_r;
  assign inflight  = inflight_r;
  assign cfg_err   = cfg_err_r;

  // Effective delay: take the (clamped) request only when nothing is in flight.
  always_comb begin
    delay_bad_s = (delay == ZERO_D) || (delay > MAX_D);
    if (inflight_r == ZERO_D) begin
      if (delay == ZERO_D) begin
        ed_s = ONE_D;
      end else if (delay > MAX_D) begin
        ed_s = MAX_D;
      end else begin
        ed_s = delay;
      end
    end else begin
      ed_s = cd_r;
    end
  end

  // Output tap: one-hot AND-OR select of stage[ed_s-1].
  always_comb begin
    tap_vld_s = 1'b0;
    tap_dat_s = {WIDTH{1'b0}};
    for (int i = 0; i < MAX_DEPTH; i++) begin
      tap_vld_s = tap_vld_s | (stage_vld_r[i] & (ed_s == DW'(i + 1)));
      tap_dat_s = tap_dat_s | (stage_dat_r[i] & {WIDTH{ed_s == DW'(i + 1)}});
    end
  end

  // Shift network; valid bits at or beyond the tap are dropped so a later
  // delay increase can never expose an old sample.
  always_comb begin
    accept_s     = valid_in & en & ~flush;
    nxt_vld_s    = {MAX_DEPTH{1'b0}};
    nxt_dat_s    = stage_dat_r;
    nxt_vld_s[0] = accept_s;
    nxt_dat_s[0] = din;
    for (int i = 1; i < MAX_DEPTH; i++) begin
      nxt_vld_s[i] = stage_vld_r[i-1] & (DW'(i) < ed_s);
      nxt_dat_s[i] = stage_dat_r[i-1];
    end
  end

  // In-flight counter: +1 on accept, -1 when a sample reaches the output.
  always_comb begin
    case ({accept_s, tap_vld_s})
      2'b10:   inflight_nxt_s = inflight_r + ONE_D;
      2'b01:   inflight_nxt_s = inflight_r - ONE_D;
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // State update: reset, then flush (over en), then enabled advance.
  // cfg_err is sampled every edge, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld_r <= {MAX_DEPTH{1'b0}};
      stage_dat_r <= {(MAX_DEPTH*WIDTH){1'b0}};
      cd_r        <= ONE_D;
      inflight_r  <= ZERO_D;
      dout_r      <= {WIDTH{1'b0}};
      valid_out_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else if (flush) begin
      stage_vld_r <= {MAX_DEPTH{1'b0}};
      inflight_r  <= ZERO_D;
      valid_out_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      if (delay_bad_s && (inflight_r == ZERO_D)) begin
        cfg_err_r <= 1'b1;
      end
      if (en) begin
        stage_vld_r <= nxt_vld_s;
        stage_dat_r <= nxt_dat_s;
        cd_r        <= ed_s;
        inflight_r  <= inflight_nxt_s;
        valid_out_r <= tap_vld_s;
        dout_r      <= tap_dat_s;
      end
    end
  end

endmodule

// File: tb/tb_var_delay_pipe.sv
// -----------------------------------------------------------------------------
// tb_var_delay_pipe
// Directed scenarios followed by random traffic. The reference model keeps a
// list of accepted samples stamped with the enabled-edge number on which each
// must appear; a monitor process pops the scoreboard whenever the DUT
// presents a new output.
// -----------------------------------------------------------------------------
module tb_var_delay_pipe;

  localparam int WIDTH = 8;
  localparam int MAXD  = 16;
  localparam int DW    = $clog2(MAXD + 1);

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } ent_t;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic [WIDTH-1:0] din      = '0;
  logic             valid_in = 1'b0;
  logic             en       = 1'b0;
  logic             flush    = 1'b0;
  logic [DW-1:0]    delay    = DW'(4);
  logic [WIDTH-1:0] dout;
  logic             valid_out;
  logic [DW-1:0]    inflight;
  logic             cfg_err;

  int   n_tests = 0;
  int   n_fail  = 0;

  // model state
  ent_t pend[$];
  ent_t exp_q[$];
  int   edge_cnt = 0;
  int   cd_m     = 1;
  int   err_m    = 0;
  int   kind     = 3;   // 0 stall, 1 advance, 2 flush, 3 unchecked
  logic             prev_vo   = 1'b0;
  logic [WIDTH-1:0] prev_dout = '0;

  var_delay_pipe #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .valid_in  (valid_in),
    .en        (en),
    .flush     (flush),
    .delay     (delay),
    .dout      (dout),
    .valid_out (valid_out),
    .inflight  (inflight),
    .cfg_err   (cfg_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk_eq(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_delay(int d);
    if (d < 1) return 1;
    if (d > MAXD) return MAXD;
    return d;
  endfunction

  // Predict the effect of the coming rising edge from the inputs just driven.
  task automatic model_edge();
    int ed;
    ent_t e;
    if (flush) begin
      pend.delete();
      exp_q.delete();
      err_m = 0;
      kind  = 2;
    end else begin
      if (pend.size() == 0 && (int'(delay) == 0 || int'(delay) > MAXD)) err_m = 1;
      if (en) begin
        ed   = (pend.size() == 0) ? clamp_delay(int'(delay)) : cd_m;
        cd_m = ed;
        edge_cnt++;
        while (pend.size() > 0 && pend[0].due == edge_cnt) void'(pend.pop_front());
        if (valid_in) begin
          e.data = din;
          e.due  = edge_cnt + ed;
          pend.push_back(e);
          exp_q.push_back(e);
        end
        kind = 1;
      end else begin
        kind = 0;
      end
    end
  endtask

  task automatic step(bit v, logic [WIDTH-1:0] d, bit e, bit f, int dl);
    @(negedge clk);
    valid_in = v;
    din      = d;
    en       = e;
    flush    = f;
    delay    = DW'(dl);
    model_edge();
  endtask

  task automatic idle(int n, int dl);
    repeat (n) step(1'b0, '0, 1'b1, 1'b0, dl);
  endtask

  task automatic async_reset();
    @(negedge clk);
    valid_in = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_eq("midrst_valid_out", valid_out, 0);
    chk_eq("midrst_dout", dout, 0);
    chk_eq("midrst_inflight", inflight, 0);
    chk_eq("midrst_cfg_err", cfg_err, 0);
    pend.delete();
    exp_q.delete();
    cd_m      = 1;
    err_m     = 0;
    prev_vo   = 1'b0;
    prev_dout = '0;
    #1 rst = 1'b0;
    model_edge();
  endtask

  // Monitor / scoreboard
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && kind != 3) begin
        case (kind)
          1: begin
            if (valid_out) begin
              if (exp_q.size() == 0) begin
                chk_eq("phantom_valid", valid_out, 0);
              end else begin
                e = exp_q.pop_front();
                chk_eq("dout", dout, e.data);
                chk_eq("latency_edge", edge_cnt, e.due);
              end
            end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
              e = exp_q.pop_front();
              chk_eq("missing_valid", valid_out, 1);
            end
          end
          0: begin
            chk_eq("stall_hold_valid", valid_out, prev_vo);
            if (prev_vo) chk_eq("stall_hold_dout", dout, prev_dout);
          end
          2: chk_eq("flush_valid_out", valid_out, 0);
          default: ;
        endcase
        chk_eq("inflight", inflight, pend.size());
        chk_eq("cfg_err", cfg_err, err_m);
      end
      prev_vo   = valid_out;
      prev_dout = dout;
    end
  end

  // Stimulus
  initial begin
    int dl;
    #1;
    chk_eq("reset_valid_out", valid_out, 0);
    chk_eq("reset_dout", dout, 0);
    chk_eq("reset_inflight", inflight, 0);
    chk_eq("reset_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // single sample, delay 4
    idle(9, 4);
    step(1'b1, 8'hA5, 1'b1, 1'b0, 4);
    idle(6, 4);

    // delay 3 back-to-back with a 2-cycle stall (valid_in ignored while stalled)
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0, 3);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 3);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 3);
    for (int i = 5; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0, 3);
    idle(5, 3);

    // delay change only takes effect once empty; no stale sample after increase
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'h30 + i), 1'b1, 1'b0, 5);
    idle(7, 2);
    step(1'b1, 8'h5C, 1'b1, 1'b0, 2);
    idle(3, 2);
    idle(12, 8);

    // flush with valid_in high
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'h60 + i), 1'b1, 1'b0, 6);
    step(1'b1, 8'h77, 1'b1, 1'b1, 6);
    idle(8, 6);

    // out-of-range delays clamp and set a sticky error
    idle(1, 0);
    step(1'b1, 8'h11, 1'b1, 1'b0, 0);
    idle(3, 0);
    step(1'b1, 8'h22, 1'b1, 1'b0, MAXD + 1);
    idle(MAXD + 2, MAXD + 1);
    idle(2, 4);
    step(1'b0, '0, 1'b0, 1'b1, 4);
    idle(2, 4);

    // asynchronous reset with samples in flight
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'h90 + i), 1'b1, 1'b0, 4);
    async_reset();
    idle(6, 4);

    // random traffic
    dl = 4;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 10) dl = int'($urandom_range(0, MAXD + 2));
      step($urandom_range(0, 99) < 60, WIDTH'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 80, $urandom_range(0, 99) == 0, dl);
    end
    idle(MAXD + 3, 4);
    @(negedge clk);
    chk_eq("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
